// File: rtl/stream_map_addk_pkg.sv
// stream_map_addk_pkg: shared FSM encoding and per-lane add/saturate helper
package stream_map_addk_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Lane values are carried zero-extended in 64 bits; w is the live lane width (1..63).
    function automatic logic [63:0] lane_add(input logic [63:0] x, input logic [63:0] a,
                                             input int w, input logic sat, input logic sgn);
        logic [64:0] s;
        logic [63:0] m, h, r;
        logic        xs, ys, rs;
        m  = (64'd1 << w) - 64'd1;
        h  = 64'd1 << (w - 1);
        s  = {1'b0, x} + {1'b0, a};
        r  = s[63:0] & m;
        xs = |(x & h);
        ys = |(a & h);
        rs = |(r & h);
        if (sat && !sgn && ((s >> w) != 65'd0))
            r = m;
        if (sat && sgn && (xs == ys) && (rs != xs))
            r = xs ? h : (m >> 1);
        return r;
    endfunction

endpackage

// File: rtl/stream_map_stage.sv
// stream_map_stage: one backpressured register slice carrying data and last
module stream_map_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_last;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    // Load a new element whenever the slot is empty or being drained; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end

endmodule

// File: rtl/stream_map_addk.sv
// stream_map_addk: call-wrapped stream map adding a per-call addend to every lane
module stream_map_addk
    import stream_map_addk_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 1,
    parameter int DEPTH  = 1,
    parameter int SAT    = 0,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       addend,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       count,
    input  logic [LANES*WIDTH-1:0] sIn,
    input  logic                   sIn_valid,
    input  logic                   sIn_last,
    output logic                   sIn_ready,
    output logic [LANES*WIDTH-1:0] sOut,
    output logic                   sOut_valid,
    output logic                   sOut_last,
    input  logic                   sOut_ready
);

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_addend;
    logic [CNT_W-1:0]       r_count;
    logic [1:0]             w_next;
    logic [DEPTH:0]         w_valid, w_rdy, w_last;
    logic [LANES*WIDTH-1:0] w_data [DEPTH+1];
    logic                   w_in_hs, w_out_hs;

    assign w_valid[0]   = (r_state == S_RUN) && sIn_valid;
    assign w_last[0]    = sIn_last;
    assign w_rdy[DEPTH] = sOut_ready;
    assign sIn_ready    = (r_state == S_RUN) && w_rdy[0];
    assign w_in_hs      = sIn_valid && sIn_ready;
    assign w_out_hs     = w_valid[DEPTH] && sOut_ready;
    assign in_ready     = r_state == S_IDLE;
    assign out_valid    = r_state == S_DONE;
    assign count        = r_count;
    assign sOut         = w_data[DEPTH];
    assign sOut_valid   = w_valid[DEPTH];
    assign sOut_last    = w_last[DEPTH];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_data[0][i*WIDTH +: WIDTH] = WIDTH'(lane_add(64'(sIn[i*WIDTH +: WIDTH]), 64'(r_addend),
                                                             WIDTH, SAT != 0, SIGNED != 0));
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        stream_map_stage #(.W(LANES*WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_last  (w_last[k]),
            .o_ready (w_rdy[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_last  (w_last[k+1]),
            .i_ready (w_rdy[k+1])
        );
    end

    // Call sequencing: start, last input accepted, last output emitted, result consumed.
    always_comb begin
        w_next = (r_state == S_IDLE  && in_valid)              ? S_RUN   :
                 (r_state == S_RUN   && w_in_hs && sIn_last)   ? S_DRAIN :
                 (r_state == S_DRAIN && w_out_hs && sOut_last) ? S_DONE  :
                 (r_state == S_DONE  && out_ready)             ? S_IDLE  : r_state;
    end

    // State, latched addend and saturating element counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addend <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && in_valid) begin
                r_addend <= addend;
                r_count  <= '0;
            end else if (w_out_hs && r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_map_addk.sv
// tb_stream_map_addk: randomized and directed checks of wrap/saturate modes against an arithmetic model
module tb_stream_map_addk;

    typedef struct {
        logic [15:0] d0, d1, d2;
        logic        l;
        int          t;
    } el_t;

    logic        clk, rst, in_valid, out_ready, sIn_valid, sIn_last, sOut_ready;
    logic [7:0]  addend;
    logic [15:0] sIn;
    logic        ir [3];
    logic        ov [3];
    logic        sr [3];
    logic        so_v [3];
    logic        so_l [3];
    logic [15:0] cn [3];
    logic [15:0] so_d [3];

    int          total = 0, passes = 0, cycle = 0;
    el_t         q[$];
    logic [7:0]  cur_k;
    logic        bp = 0, lat_chk = 0, in_hs = 0;
    logic        hold_v = 0, hold_l;
    logic [15:0] hold_d;

    // Instance 0 wraps, 1 saturates unsigned, 2 saturates signed; all share the stimulus.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        stream_map_addk #(.WIDTH(8), .LANES(2), .DEPTH(3), .SAT(g > 0 ? 1 : 0),
                          .SIGNED(g == 2 ? 1 : 0), .CNT_W(16)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (ir[g]),
            .addend     (addend),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .count      (cn[g]),
            .sIn        (sIn),
            .sIn_valid  (sIn_valid),
            .sIn_last   (sIn_last),
            .sIn_ready  (sr[g]),
            .sOut       (so_d[g]),
            .sOut_valid (so_v[g]),
            .sOut_last  (so_l[g]),
            .sOut_ready (sOut_ready)
        );
    end

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mdl(int x, int k, int m);
        int sx, sk, s;
        if (m == 0) return 8'((x + k) % 256);
        if (m == 1) return 8'((x + k > 255) ? 255 : x + k);
        sx = (x > 127) ? x - 256 : x;
        sk = (k > 127) ? k - 256 : k;
        s  = sx + sk;
        s  = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        return 8'(s);
    endfunction

    function automatic logic [15:0] exp_el(logic [15:0] d, logic [7:0] k, int m);
        return {mdl(int'(d[15:8]), int'(k), m), mdl(int'(d[7:0]), int'(k), m)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        el_t e;
        sOut_ready = bp ? ((cycle % 4 == 0) || (cycle % 4 == 3)) : 1'b1;
        #1;
        if (hold_v && so_v[0]) begin
            chk("stall data hold", so_d[0], hold_d);
            chk("stall last hold", so_l[0], hold_l);
        end
        in_hs = sIn_valid && sr[0];
        if (in_hs)
            q.push_back('{exp_el(sIn, cur_k, 0), exp_el(sIn, cur_k, 1), exp_el(sIn, cur_k, 2), sIn_last, cycle});
        if (so_v[0] && sOut_ready) begin
            if (q.size() == 0) begin
                chk("unexpected sOut", so_v[0], 0);
            end else begin
                e = q.pop_front();
                chk("sOut wrap", so_d[0], e.d0);
                chk("sOut usat", so_d[1], e.d1);
                chk("sOut ssat", so_d[2], e.d2);
                chk("sOut_last", so_l[0], e.l);
                chk("usat valid", so_v[1], 1);
                chk("ssat valid", so_v[2], 1);
                if (lat_chk) chk("latency", cycle - e.t, 3);
            end
        end
        hold_v = so_v[0] && !sOut_ready;
        hold_d = so_d[0];
        hold_l = so_l[0];
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic start(logic [7:0] k);
        chk("in_ready idle", ir[0], 1);
        chk("sIn_ready idle", sr[0], 0);
        addend   = k;
        cur_k    = k;
        in_valid = 1;
        cyc();
        in_valid = 0;
    endtask

    task automatic send(logic [15:0] d, logic l);
        logic got = 0;
        sIn       = d;
        sIn_last  = l;
        sIn_valid = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            got = in_hs;
        end
        sIn_valid = 0;
        sIn_last  = 0;
        chk("element accepted", got, 1);
    endtask

    task automatic finish(int n);
        for (int i = 0; i < 60 && !ov[0]; i++) cyc();
        chk("out_valid", ov[0], 1);
        chk("count", cn[0], n);
        chk("drained", q.size(), 0);
        chk("sIn_ready done", sr[0], 0);
        cyc();
        cyc();
        chk("out_valid held", ov[0], 1);
        chk("count held", cn[0], n);
        chk("in_ready busy", ir[0], 0);
        out_ready = 1;
        cyc();
        out_ready = 0;
        chk("in_ready back", ir[0], 1);
        chk("out_valid clear", ov[0], 0);
    endtask

    initial begin
        int c0, n;
        rst = 1; in_valid = 0; out_ready = 0; sIn_valid = 0; sIn_last = 0; sOut_ready = 1;
        addend = 0; sIn = 0; cur_k = 0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 0;
        chk("rst in_ready", ir[0], 1);
        chk("rst out_valid", ov[0], 0);
        chk("rst sIn_ready", sr[0], 0);
        chk("rst sOut_valid", so_v[0], 0);
        chk("rst sOut_last", so_l[0], 0);
        chk("rst sOut", so_d[0], 0);
        chk("rst count", cn[0], 0);

        start(8'd2);
        lat_chk = 1;
        c0 = cycle;
        send(16'h0A05, 0);
        for (int j = 0; j < 3; j++) send(16'($urandom), 0);
        send(16'($urandom), 1);
        chk("throughput", cycle - c0, 5);
        finish(5);
        lat_chk = 0;

        start(8'd3);
        send(16'h05FE, 0);
        in_valid = 1;
        addend   = 8'h55;
        send(16'($urandom), 0);
        in_valid = 0;
        send(16'($urandom), 1);
        finish(3);

        start(8'h7F);
        send(16'h8005, 0);
        send(16'($urandom), 0);
        send(16'($urandom), 1);
        finish(3);

        start(8'h80);
        send(16'h10F0, 1);
        finish(1);

        bp = 1;
        start(8'($urandom));
        for (int j = 0; j < 8; j++) send(16'($urandom), j == 7);
        finish(8);
        bp = 0;

        for (int c = 0; c < 3; c++) begin
            n = $urandom_range(1, 6);
            start(8'($urandom));
            for (int j = 0; j < n; j++) send(16'($urandom), j == n - 1);
            finish(n);
        end

        start(8'd9);
        send(16'h1234, 0);
        send(16'h5678, 0);
        rst = 1;
        cyc();
        rst = 0;
        q.delete();
        hold_v = 0;
        chk("midrst sOut_valid", so_v[0], 0);
        chk("midrst out_valid", ov[0], 0);
        chk("midrst in_ready", ir[0], 1);
        start(8'd5);
        send(16'h0000, 1);
        finish(1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
